data_memory_pipelined: RTL

Parametrised, pipelined data memory for the mips16 datapath and its wider derivatives. It replaces the single-cycle, word-only data RAM with three additions:
- a valid/ready request port with per-byte write strobes;
- a configurable registered read latency;
- misalignment and range error reporting.

It sits between the load/store stage and the writeback stage. Read data returns in request order after a fixed latency.

---
 rtl/data_memory_pipelined.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/data_memory_pipelined.sv
// Pipelined byte-strobed data memory with in-order, fixed-latency reads and error reporting.
// Optional power-up clear sweep enabled by defining DATA_MEMORY_CLEAR_EN.
module data_memory_pipelined #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int DEPTH_LOG2   = 15,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_error,
    output logic                    busy
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int B     = $clog2(LANES);
    localparam int WORDS = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {ST_INIT, ST_CLEAR, ST_READY} state_t;

    state_t state_q, state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

`ifdef DATA_MEMORY_CLEAR_EN
    logic [DEPTH_LOG2-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) clr_cnt_q <= '0;
        else       clr_cnt_q <= clr_cnt_d;
    end
`endif

    always_comb begin
        state_d = state_q;
`ifdef DATA_MEMORY_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
`endif
        case (state_q)
`ifdef DATA_MEMORY_CLEAR_EN
            ST_INIT:  state_d = ST_CLEAR;
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + DEPTH_LOG2'(1);
                if (&clr_cnt_q) state_d = ST_READY;
            end
`else
            ST_INIT:  state_d = ST_READY;
`endif
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_READY);
        busy      = (state_q != ST_READY);
    end

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic                  misaligned, out_of_range, acc_err, accept, rd_en;

    assign word_addr    = req_addr >> B;
    assign mem_idx      = word_addr[DEPTH_LOG2-1:0];
    assign misaligned   = |req_addr[B-1:0];
    assign out_of_range = |(word_addr >> DEPTH_LOG2);
    assign acc_err      = misaligned | out_of_range;
    assign accept       = req_valid & req_ready;
    assign rd_en        = accept & ~req_write;

    // Single write port shared by the request path and the clear sweep.
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [LANES-1:0]      wr_be;

    always_comb begin
        wr_en   = accept & req_write & ~acc_err;
        wr_idx  = mem_idx;
        wr_data = req_wdata;
        wr_be   = req_be;
`ifdef DATA_MEMORY_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = clr_cnt_q;
            wr_data = '0;
            wr_be   = '1;
        end
`endif
    end

    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Stage data only advances with a valid read, so the last stage holds between responses.
    logic                  vld_q   [READ_LATENCY];
    logic                  err_q   [READ_LATENCY];
    logic [DATA_WIDTH-1:0] rdata_q [READ_LATENCY];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_q[i]   <= 1'b0;
                err_q[i]   <= 1'b0;
                rdata_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en;
            if (rd_en) begin
                err_q[0]   <= acc_err;
                rdata_q[0] <= acc_err ? '0 : mem_q[mem_idx];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    err_q[i]   <= err_q[i-1];
                    rdata_q[i] <= rdata_q[i-1];
                end
            end
        end
    end

    assign resp_valid = vld_q[READ_LATENCY-1];
    assign resp_rdata = rdata_q[READ_LATENCY-1];
    assign resp_error = vld_q[READ_LATENCY-1] & err_q[READ_LATENCY-1];

endmodule
